// File: rtl/cache_miss_arbiter_pkg.sv
// Shared cache package for the miss arbiter slice.
// Holds the bus widths, the arbiter state encoding and the owner encoding
// so the interface, the picker and the arbiter all agree on them.
package cache_miss_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_LAUNCH,
    ST_FILL,
    ST_DONE
  } arb_state_t;

  // Owner bit: which cache the current fill belongs to.
  localparam logic OWNER_D = 1'b0;
  localparam logic OWNER_I = 1'b1;

endpackage

// File: rtl/cache_miss_arbiter_if.sv
// Bundle of every request, fill-FSM and memory-write signal around the
// miss arbiter.
//   slave  modport : the arbiter (takes requests and FSM status, drives
//                    launch, steered strobes, stalls and the write port)
//   master modport : the surrounding pipeline / fill FSM / memory side
interface cache_miss_arbiter_if;
  import cache_miss_arbiter_pkg::*;

  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;

  logic              fsm_busy;
  logic              fsm_wen_cache;
  logic              fsm_wen_tag;

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              i_wen_cache;
  logic              i_wen_tag;
  logic              d_wen_cache;
  logic              d_wen_tag;
  logic              i_stall;
  logic              d_stall;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              d_wr_ack;

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  fsm_busy, fsm_wen_cache, fsm_wen_tag,
    output miss_detected, miss_address,
    output i_wen_cache, i_wen_tag, d_wen_cache, d_wen_tag,
    output i_stall, d_stall,
    output mem_wr_en, mem_wr_addr, mem_wr_data, d_wr_ack
  );

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output fsm_busy, fsm_wen_cache, fsm_wen_tag,
    input  miss_detected, miss_address,
    input  i_wen_cache, i_wen_tag, d_wen_cache, d_wen_tag,
    input  i_stall, d_stall,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, d_wr_ack
  );

endinterface

// File: rtl/cache_miss_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker between the D and I miss requests.
//   req_d, req_i : pending miss requests
//   last         : owner of the most recently completed fill (0=D, 1=I)
//   grant        : at least one request is pending
//   owner        : chosen requester (0=D, 1=I); on a tie the one that did
//                  not go last wins
module rr_pick2
  import cache_miss_arbiter_pkg::*;
(
  input  logic req_d,
  input  logic req_i,
  input  logic last,
  output logic grant,
  output logic owner
);

  always_comb begin
    grant = req_d | req_i;
    if (req_d && req_i) begin
      owner = ~last;
    end else if (req_i) begin
      owner = OWNER_I;
    end else begin
      owner = OWNER_D;
    end
  end

endmodule

// File: rtl/cache_miss_arbiter.sv
// Arbitrates I-cache misses, D-cache misses and D-cache write-throughs onto
// a single fill FSM and memory write port.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of cache_miss_arbiter_if (requests, fill-FSM
//                status/strobes in; launch, steered strobes, stalls and the
//                memory write port out)
// A write-through always wins in IDLE; otherwise misses are picked round-robin.
// Every output is held at 0 while rst_n is low.
module cache_miss_arbiter
  import cache_miss_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  cache_miss_arbiter_if.slave  bus
);

  arb_state_t        state, state_next;
  logic              owner, owner_next;
  logic              last_owner, last_owner_next;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_next;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_next;
  logic [DATA_W-1:0] wr_data_q, wr_data_next;
  logic              pick_grant, pick_owner;
  logic              steer, done_i, done_d;

  rr_pick2 u_pick (
    .req_d (bus.d_miss),
    .req_i (bus.i_miss),
    .last  (last_owner),
    .grant (pick_grant),
    .owner (pick_owner)
  );

  // last_owner resets to I so that the very first tie goes to D.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= OWNER_D;
      last_owner  <= OWNER_I;
      miss_addr_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      last_owner  <= last_owner_next;
      miss_addr_q <= miss_addr_next;
      wr_addr_q   <= wr_addr_next;
      wr_data_q   <= wr_data_next;
    end
  end

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    miss_addr_next  = miss_addr_q;
    wr_addr_next    = wr_addr_q;
    wr_data_next    = wr_data_q;

    bus.miss_detected = 1'b0;
    bus.miss_address  = '0;
    bus.mem_wr_en     = 1'b0;
    bus.mem_wr_addr   = '0;
    bus.mem_wr_data   = '0;
    bus.d_wr_ack      = 1'b0;

    unique case (state)
      // Requests are only sampled here; anything that changes in the other
      // states is ignored until we come back.
      ST_IDLE: begin
        if (bus.d_wr_req) begin
          state_next   = ST_WRITE;
          wr_addr_next = bus.d_wr_addr;
          wr_data_next = bus.d_wr_data;
        end else if (pick_grant) begin
          state_next     = ST_LAUNCH;
          owner_next     = pick_owner;
          miss_addr_next = (pick_owner == OWNER_I) ? bus.i_miss_addr : bus.d_miss_addr;
        end
      end
      ST_WRITE: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = wr_addr_q;
        bus.mem_wr_data = wr_data_q;
        bus.d_wr_ack    = 1'b1;
        state_next      = ST_IDLE;
      end
      ST_LAUNCH: begin
        bus.miss_detected = 1'b1;
        bus.miss_address  = miss_addr_q;
        state_next        = ST_FILL;
      end
      ST_FILL: begin
        bus.miss_address = miss_addr_q;
        if (!bus.fsm_busy) begin
          state_next      = ST_DONE;
          last_owner_next = owner;
        end
      end
      ST_DONE: begin
        bus.miss_address = miss_addr_q;
        state_next       = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Fill strobes only reach the owning cache while a fill is in flight.
    steer  = (state == ST_LAUNCH) || (state == ST_FILL);
    done_i = (state == ST_DONE) && (owner == OWNER_I);
    done_d = (state == ST_DONE) && (owner == OWNER_D);

    bus.i_wen_cache = steer && (owner == OWNER_I) && bus.fsm_wen_cache;
    bus.i_wen_tag   = steer && (owner == OWNER_I) && bus.fsm_wen_tag;
    bus.d_wen_cache = steer && (owner == OWNER_D) && bus.fsm_wen_cache;
    bus.d_wen_tag   = steer && (owner == OWNER_D) && bus.fsm_wen_tag;

    // DONE releases the owner for one cycle so it can re-probe and hit.
    bus.i_stall = bus.i_miss && !done_i;
    bus.d_stall = (bus.d_miss && !done_d) || (bus.d_wr_req && (state != ST_WRITE));

    if (!rst_n) begin
      bus.miss_detected = 1'b0;
      bus.miss_address  = '0;
      bus.i_wen_cache   = 1'b0;
      bus.i_wen_tag     = 1'b0;
      bus.d_wen_cache   = 1'b0;
      bus.d_wen_tag     = 1'b0;
      bus.i_stall       = 1'b0;
      bus.d_stall       = 1'b0;
      bus.mem_wr_en     = 1'b0;
      bus.mem_wr_addr   = '0;
      bus.mem_wr_data   = '0;
      bus.d_wr_ack      = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Self-checking bench for cache_miss_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_cache_miss_arbiter;
  import cache_miss_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cache_miss_arbiter_if bus();

  cache_miss_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Staged stimulus, copied onto the bus at the next falling edge.
  logic        s_rst_n, s_i_miss, s_d_miss, s_d_wr, s_busy, s_wc, s_wt;
  logic [15:0] s_i_addr, s_d_addr, s_wr_addr, s_wr_data;

  // Reference model: one transaction at a time, either a write or a fill.
  // A fill is "launching" on its first cycle and "over" for its last cycle.
  bit          m_active    = 1'b0;
  bit          m_is_write  = 1'b0;
  bit          m_fill_over = 1'b0;
  bit          m_owner_i   = 1'b0;
  bit          m_last_i    = 1'b1;
  int          m_age       = 0;
  logic [15:0] m_addr      = '0;
  logic [15:0] m_waddr     = '0;
  logic [15:0] m_wdata     = '0;

  function automatic logic [56:0] expected_outputs();
    logic fill, wr, steer, launch, done_i, done_d;
    logic [56:0] v;
    fill   = m_active && !m_is_write;
    wr     = m_active && m_is_write;
    steer  = fill && !m_fill_over;
    launch = steer && (m_age == 0);
    done_i = fill && m_fill_over && m_owner_i;
    done_d = fill && m_fill_over && !m_owner_i;
    v = {launch, (fill ? m_addr : 16'h0000),
         steer && m_owner_i && bus.fsm_wen_cache, steer && m_owner_i && bus.fsm_wen_tag,
         steer && !m_owner_i && bus.fsm_wen_cache, steer && !m_owner_i && bus.fsm_wen_tag,
         bus.i_miss && !done_i, (bus.d_miss && !done_d) || (bus.d_wr_req && !wr),
         wr, (wr ? m_waddr : 16'h0000), (wr ? m_wdata : 16'h0000), wr};
    if (!rst_n) v = '0;
    return v;
  endfunction

  function automatic logic [56:0] observed_outputs();
    return {bus.miss_detected, bus.miss_address,
            bus.i_wen_cache, bus.i_wen_tag, bus.d_wen_cache, bus.d_wen_tag,
            bus.i_stall, bus.d_stall,
            bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.d_wr_ack};
  endfunction

  // Advance the model by one clock using what was on the bus at the edge.
  task automatic modelStep();
    if (!rst_n) begin
      m_active = 0; m_is_write = 0; m_fill_over = 0; m_owner_i = 0; m_last_i = 1;
      m_age = 0; m_addr = '0; m_waddr = '0; m_wdata = '0;
    end else if (!m_active) begin
      if (bus.d_wr_req) begin
        m_active = 1; m_is_write = 1;
        m_waddr = bus.d_wr_addr; m_wdata = bus.d_wr_data;
      end else if (bus.i_miss || bus.d_miss) begin
        m_owner_i = (bus.i_miss && bus.d_miss) ? !m_last_i : bus.i_miss;
        m_addr = m_owner_i ? bus.i_miss_addr : bus.d_miss_addr;
        m_active = 1; m_is_write = 0; m_fill_over = 0; m_age = 0;
      end
    end else if (m_is_write || m_fill_over) begin
      m_active = 0;
    end else begin
      if (m_age > 0 && !bus.fsm_busy) begin
        m_fill_over = 1;
        m_last_i = m_owner_i;
      end
      m_age++;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [56:0] exp_v, obs_v;
    exp_v = expected_outputs();
    obs_v = observed_outputs();
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: model catches up on the rising edge, staged inputs go out on
  // the falling edge, outputs are compared shortly after.
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    rst_n             = s_rst_n;
    bus.i_miss        = s_i_miss;
    bus.i_miss_addr   = s_i_addr;
    bus.d_miss        = s_d_miss;
    bus.d_miss_addr   = s_d_addr;
    bus.d_wr_req      = s_d_wr;
    bus.d_wr_addr     = s_wr_addr;
    bus.d_wr_data     = s_wr_data;
    bus.fsm_busy      = s_busy;
    bus.fsm_wen_cache = s_wc;
    bus.fsm_wen_tag   = s_wt;
    #1;
    checkOutput(tag);
  endtask

  task automatic clearInputs();
    s_rst_n = 1; s_i_miss = 0; s_d_miss = 0; s_d_wr = 0; s_busy = 0; s_wc = 0; s_wt = 0;
    s_i_addr = '0; s_d_addr = '0; s_wr_addr = '0; s_wr_data = '0;
  endtask

  initial begin
    rst_n = 0;
    bus.i_miss = 0; bus.i_miss_addr = '0; bus.d_miss = 0; bus.d_miss_addr = '0;
    bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
    bus.fsm_busy = 0; bus.fsm_wen_cache = 0; bus.fsm_wen_tag = 0;

    // Reset with busy requests and strobes present: everything stays quiet.
    clearInputs();
    s_rst_n = 0; s_i_miss = 1; s_d_wr = 1; s_busy = 1; s_wc = 1; s_wt = 1;
    applyStimulus("reset_hold");
    checkValue("reset_i_stall", bus.i_stall, 0);
    checkValue("reset_mem_wr_en", bus.mem_wr_en, 0);
    applyStimulus("reset_hold2");
    clearInputs();
    applyStimulus("idle_quiet");
    checkValue("idle_miss_detected", bus.miss_detected, 0);

    // D miss with a nine-cycle fill.
    s_d_miss = 1; s_d_addr = 16'h1230; s_busy = 1;
    applyStimulus("t1_request");
    checkValue("t1_no_launch_yet", bus.miss_detected, 0);
    checkValue("t1_d_stall", bus.d_stall, 1);
    s_wc = 1;
    applyStimulus("t1_launch");
    checkValue("t1_launch_pulse", bus.miss_detected, 1);
    checkValue("t1_launch_addr", bus.miss_address, 16'h1230);
    checkValue("t1_launch_d_wen_cache", bus.d_wen_cache, 1);
    for (int k = 1; k <= 8; k++) begin
      s_wc = k[0]; s_wt = k[1];
      applyStimulus("t1_fill");
      checkValue("t1_single_pulse", bus.miss_detected, 0);
      checkValue("t1_d_wen_tag", bus.d_wen_tag, {31'b0, s_wt});
      checkValue("t1_i_wen_cache", bus.i_wen_cache, 0);
    end
    s_busy = 0; s_wc = 0; s_wt = 0;
    applyStimulus("t1_fill_end");
    checkValue("t1_fill_end_stall", bus.d_stall, 1);
    applyStimulus("t1_done");
    checkValue("t1_done_d_stall", bus.d_stall, 0);
    checkValue("t1_done_addr_stable", bus.miss_address, 16'h1230);
    s_d_miss = 0;
    applyStimulus("t1_idle");

    // Simultaneous misses from reset: D first, then I, then D again.
    s_rst_n = 0;
    applyStimulus("t2_reset");
    clearInputs();
    s_i_miss = 1; s_i_addr = 16'h0040; s_d_miss = 1; s_d_addr = 16'h8000;
    applyStimulus("t2_tie");
    applyStimulus("t2_launch_d");
    checkValue("t2_first_is_d", bus.miss_address, 16'h8000);
    applyStimulus("t2_fill_d");
    applyStimulus("t2_done_d");
    s_d_miss = 0;
    applyStimulus("t2_idle");
    applyStimulus("t2_launch_i");
    checkValue("t2_second_is_i", bus.miss_address, 16'h0040);
    checkValue("t2_launch_i_pulse", bus.miss_detected, 1);
    applyStimulus("t2_fill_i");
    s_d_miss = 1; s_i_addr = 16'h0044;
    applyStimulus("t2_done_i");
    checkValue("t2_done_i_stall", bus.i_stall, 0);
    checkValue("t2_done_i_d_stall", bus.d_stall, 1);
    applyStimulus("t2_tie2");
    applyStimulus("t2_launch_tie2");
    checkValue("t2_third_is_d", bus.miss_address, 16'h8000);
    applyStimulus("t2_fill3");
    clearInputs();
    applyStimulus("t2_done3");
    applyStimulus("t2_idle3");

    // Write-through beats a pending D miss.
    s_d_wr = 1; s_wr_addr = 16'h0ABC; s_wr_data = 16'hBEEF; s_d_miss = 1; s_d_addr = 16'h2222;
    applyStimulus("t3_request");
    checkValue("t3_no_write_yet", bus.mem_wr_en, 0);
    applyStimulus("t3_write");
    checkValue("t3_mem_wr_en", bus.mem_wr_en, 1);
    checkValue("t3_mem_wr_addr", bus.mem_wr_addr, 16'h0ABC);
    checkValue("t3_mem_wr_data", bus.mem_wr_data, 16'hBEEF);
    checkValue("t3_ack", bus.d_wr_ack, 1);
    s_d_wr = 0;
    applyStimulus("t3_after_write");
    checkValue("t3_ack_one_cycle", bus.d_wr_ack, 0);
    applyStimulus("t3_launch");
    checkValue("t3_launch_d", bus.miss_detected, 1);
    checkValue("t3_launch_addr", bus.miss_address, 16'h2222);
    applyStimulus("t3_fill");
    s_d_miss = 0;
    applyStimulus("t3_done");
    applyStimulus("t3_idle");

    // Write request arriving mid-fill waits for the fill to finish.
    s_i_miss = 1; s_i_addr = 16'h0100; s_busy = 1;
    applyStimulus("t4_request");
    applyStimulus("t4_launch");
    s_d_wr = 1; s_wr_addr = 16'h0200; s_wr_data = 16'h1111;
    for (int k = 0; k < 4; k++) begin
      applyStimulus("t4_fill");
      checkValue("t4_no_write", bus.mem_wr_en, 0);
      checkValue("t4_d_stall", bus.d_stall, 1);
    end
    s_busy = 0;
    applyStimulus("t4_fill_end");
    applyStimulus("t4_done");
    checkValue("t4_done_no_write", bus.mem_wr_en, 0);
    s_i_miss = 0;
    applyStimulus("t4_idle");
    applyStimulus("t4_write");
    checkValue("t4_write_addr", bus.mem_wr_addr, 16'h0200);
    s_d_wr = 0;
    applyStimulus("t4_after");

    // Reset in the middle of a fill.
    s_d_miss = 1; s_d_addr = 16'h3333; s_busy = 1; s_wc = 1; s_wt = 1;
    applyStimulus("t5_request");
    applyStimulus("t5_launch");
    applyStimulus("t5_fill");
    s_rst_n = 0;
    applyStimulus("t5_reset_cycle");
    checkValue("t5_reset_no_steer", bus.d_wen_cache, 0);
    s_rst_n = 1; s_d_miss = 0;
    applyStimulus("t5_after_reset");
    checkValue("t5_idle_no_steer", bus.d_wen_tag, 0);
    checkValue("t5_idle_no_launch", bus.miss_detected, 0);
    clearInputs();
    applyStimulus("t5_idle");

    // I miss dropped mid-fill still completes.
    s_i_miss = 1; s_i_addr = 16'h0300; s_busy = 1;
    applyStimulus("t6_request");
    applyStimulus("t6_launch");
    applyStimulus("t6_fill");
    s_i_miss = 0; s_wt = 1;
    applyStimulus("t6_fill_dropped");
    checkValue("t6_i_wen_tag", bus.i_wen_tag, 1);
    s_busy = 0; s_wt = 0;
    applyStimulus("t6_fill_end");
    applyStimulus("t6_done");
    checkValue("t6_done_addr", bus.miss_address, 16'h0300);
    applyStimulus("t6_idle");

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s_rst_n   = ($urandom_range(0, 59) != 0);
      s_i_miss  = ($urandom_range(0, 2) == 0);
      s_d_miss  = ($urandom_range(0, 2) == 0);
      s_d_wr    = ($urandom_range(0, 5) == 0);
      s_busy    = ($urandom_range(0, 3) != 0);
      s_wc      = 1'($urandom_range(0, 1));
      s_wt      = 1'($urandom_range(0, 1));
      s_i_addr  = 16'($urandom);
      s_d_addr  = 16'($urandom);
      s_wr_addr = 16'($urandom);
      s_wr_data = 16'($urandom);
      applyStimulus("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_arbiter.md
CACHE_MISS_ARBITER -- requirements
Module: cache_miss_arbiter

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-003 SHALL have i_miss / i_miss_addr, input, 1/16, I-cache miss request and byte address.
REQ-004 SHALL have d_miss / d_miss_addr, input, 1/16, D-cache miss request and byte address.
REQ-005 SHALL have d_wr_req / d_wr_addr / d_wr_data, input, 1/16/16, D-cache write-through request.
REQ-006 SHALL have fsm_busy, fsm_wen_cache, fsm_wen_tag, input, 1 each, status and strobes from the fill FSM.
REQ-007 SHALL have miss_detected / miss_address, output, 1/16, launch to the fill FSM.
REQ-008 SHALL have i_wen_cache, i_wen_tag, d_wen_cache, d_wen_tag, output, 1 each, steered fill strobes.
REQ-009 SHALL have i_stall / d_stall, output, 1 each, hold the requesting pipeline stage.
REQ-010 SHALL have mem_wr_en / mem_wr_addr / mem_wr_data, output, 1/16/16, memory write port; d_wr_ack, output, 1, write accepted.

Function
REQ-011 SHALL implement states IDLE, WRITE, LAUNCH, FILL, DONE, plus owner bit (0=D, 1=I) and last_owner bit.
REQ-012 SHALL, in IDLE, select by priority: d_wr_req -> WRITE; else one miss -> LAUNCH with that owner; both misses -> owner = ~last_owner.
REQ-013 SHALL latch the selected miss address on the IDLE->LAUNCH edge; miss_address stable from LAUNCH through DONE.
REQ-014 SHALL assert miss_detected only in LAUNCH, exactly one cycle; LAUNCH -> FILL unconditionally.
REQ-015 SHALL remain in FILL while fsm_busy=1; fsm_busy=0 in FILL -> DONE; update last_owner on FILL->DONE.
REQ-016 SHALL route fsm_wen_cache/fsm_wen_tag to the owner's outputs only in LAUNCH/FILL; non-owner strobes 0; all strobes 0 in other states.
REQ-017 SHALL spend exactly one cycle in DONE, then IDLE; DONE gives the owner one cycle to re-probe and hit.
REQ-018 SHALL, in WRITE, drive mem_wr_en=1, mem_wr_addr/data = registered d_wr_addr/data, d_wr_ack=1 for one cycle, then IDLE.
REQ-019 SHALL compute i_stall = i_miss & ~(state==DONE & owner==I); d_stall = (d_miss & ~(state==DONE & owner==D)) | (d_wr_req & state!=WRITE).
REQ-020 SHALL ignore request changes outside IDLE; a miss dropped mid-fill does not abort the fill.
REQ-021 SHALL never issue a write in LAUNCH/FILL/DONE; writes and fills never overlap.
REQ-022 SHALL ignore an unexpected fsm_busy=1 in IDLE/WRITE (no strobe steering).
REQ-023 SHALL give worst-case miss-to-launch latency of 2 cycles when IDLE (1 registered select + LAUNCH).

Reset
REQ-024 SHALL, with rst_n=0 at a clk edge, enter IDLE, clear owner, last_owner=I (D wins first tie), clear latched addresses/data.
REQ-025 SHALL drive all outputs 0 during reset and in IDLE with no requests; reset mid-FILL returns to IDLE with no further strobes.

Structure
REQ-026 SHALL take state encodings, ADDR_W=16 and DATA_W=16 from the shared cache package.
REQ-027 SHALL use one sub-module, rr_pick2, a combinational two-way round-robin picker (req_d, req_i, last -> grant, owner).

Verification
REQ-028 d_miss=1, addr 0x1230, fsm_busy high 9 cycles -> miss_detected one cycle 2 cycles after request, miss_address=0x1230, d_wen_* follow fsm strobes, i_wen_*=0, d_stall drops in DONE.
REQ-029 i_miss (0x0040) and d_miss (0x8000) same cycle from reset -> D served first, then I launched with 0x0040; next tie after that goes D.
REQ-030 d_wr_req addr 0x0ABC data 0xBEEF with d_miss pending -> WRITE first: mem_wr_en=1, addr 0x0ABC, data 0xBEEF, d_wr_ack one cycle, then LAUNCH for D miss.
REQ-031 d_wr_req asserted during FILL -> mem_wr_en stays 0 until after DONE; d_stall=1 throughout.
REQ-032 rst_n=0 mid-FILL -> next cycle IDLE, all outputs 0, fsm strobes not steered.
REQ-033 i_miss drops mid-FILL -> fill completes, i_wen_tag still pulses, DONE then IDLE.
